mult_div_unit: RTL and testbench

Sequential signed 32-bit multiply/divide unit for the multicycle CPU. Produces HI and LO for MULT and DIV; the HI and LO outputs feed the write-back data select ahead of the register bank (MFHI/MFLO paths). The main control FSM starts it with a one-cycle pulse and stalls until `done`. The multiplier is radix-2 Booth and the divider is restoring, each taking 32 iteration cycles.

---
 rtl/mult_div_pkg.sv | 24 ++
 rtl/booth_mult_core.sv | 56 +++++
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_pkg : shared types and constants for the multiply/divide unit
// Rev 1.0
// ============================================================================
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic [MD_WIDTH-1:0] md_neg_if(input logic neg, input logic [MD_WIDTH-1:0] v);
    return neg ? (~v + {{(MD_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_core.sv
`default_nettype none
// ============================================================================
// booth_mult_core : radix-2 Booth register {A[32:0], Q[31:0], q_-1} and step
// Rev 1.0
// ============================================================================
module booth_mult_core
  import mult_div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_init,
  input  logic                    i_step,
  input  logic [MD_WIDTH-1:0]     i_a,
  input  logic [MD_WIDTH-1:0]     i_b,
  output logic [2*MD_WIDTH-1:0]   o_prod_nxt
);

  logic [MD_WIDTH:0]     r_acc;
  logic [MD_WIDTH-1:0]   r_q;
  logic                  r_q_m1;

  logic [MD_WIDTH:0]     w_b_ext;
  logic [MD_WIDTH:0]     w_sum;
  logic [2*MD_WIDTH+1:0] w_shifted;

  // o_prod_nxt is the product as it will be after the current step, so the
  // top can capture hi/lo on the same edge that performs the final step.
  always_comb begin
    w_b_ext = {i_b[MD_WIDTH-1], i_b};
    case ({r_q[0], r_q_m1})
      2'b01:   w_sum = r_acc + w_b_ext;
      2'b10:   w_sum = r_acc - w_b_ext;
      default: w_sum = r_acc;
    endcase
    w_shifted  = {w_sum[MD_WIDTH], w_sum, r_q};
    o_prod_nxt = w_shifted[2*MD_WIDTH:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
    end else if (i_init) begin
      r_acc  <= '0;
      r_q    <= i_a;
      r_q_m1 <= 1'b0;
    end else if (i_step) begin
      r_acc  <= w_shifted[2*MD_WIDTH+1:MD_WIDTH+1];
      r_q    <= w_shifted[MD_WIDTH:1];
      r_q_m1 <= w_shifted[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : sequential signed 32-bit MULT (Booth) / DIV (restoring).
// Optional divide-by-zero detection: define MULT_DIV_ZERO_EXC_EN.  Rev 1.0
// ============================================================================
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_mult,
  input  logic                start_div,
  input  logic [MD_WIDTH-1:0] a,
  input  logic [MD_WIDTH-1:0] b,
  output logic [MD_WIDTH-1:0] hi,
  output logic [MD_WIDTH-1:0] lo,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);

  md_state_t             r_state;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [MD_WIDTH-1:0]   r_a, r_b;
  logic [MD_WIDTH-1:0]   r_rem, r_quo, r_dvsr;
  logic [MD_WIDTH-1:0]   r_hi, r_lo;
  logic                  r_busy, r_done;

  logic                  w_accept_mult;
  logic                  w_last;
  logic                  w_dz_hit;
  logic [2*MD_WIDTH-1:0] w_prod;
  logic [MD_WIDTH:0]     w_trial;
  logic [MD_WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [MD_WIDTH-1:0]   w_div_hi, w_div_lo;

  assign w_accept_mult = (r_state == IDLE) && start_mult;
  assign w_last        = (r_cnt == MD_CNT_W'(MD_ITERS - 1));

`ifdef MULT_DIV_ZERO_EXC_EN
  logic r_div_zero;
  assign w_dz_hit = (b == '0);
  assign div_zero = r_div_zero;
`else
  assign w_dz_hit = 1'b0;
  assign div_zero = 1'b0;
`endif

  booth_mult_core u_booth (
    .clk        (clk),
    .rst        (reset),
    .i_init     (w_accept_mult),
    .i_step     (r_state == MULT),
    .i_a        (a),
    .i_b        (r_b),
    .o_prod_nxt (w_prod)
  );

  // Restoring step on magnitudes; the sign fix is folded into the final edge.
  always_comb begin
    w_trial   = {r_rem, r_quo[MD_WIDTH-1]} - {1'b0, r_dvsr};
    w_rem_nxt = w_trial[MD_WIDTH] ? {r_rem[MD_WIDTH-2:0], r_quo[MD_WIDTH-1]} : w_trial[MD_WIDTH-1:0];
    w_quo_nxt = {r_quo[MD_WIDTH-2:0], ~w_trial[MD_WIDTH]};
    if (r_b == '0) begin
      w_div_hi = r_a;
      w_div_lo = '1;
    end else begin
      w_div_hi = md_neg_if(r_a[MD_WIDTH-1], w_rem_nxt);
      w_div_lo = md_neg_if(r_a[MD_WIDTH-1] ^ r_b[MD_WIDTH-1], w_quo_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULT_DIV_ZERO_EXC_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MULT_DIV_ZERO_EXC_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (start_mult) begin
            r_state <= MULT;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
          end else if (start_div) begin
            r_a <= a;
            r_b <= b;
            if (w_dz_hit) begin
              r_state <= DONE;
              r_done  <= 1'b1;
`ifdef MULT_DIV_ZERO_EXC_EN
              r_div_zero <= 1'b1;
`endif
            end else begin
              r_state <= DIV;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= md_neg_if(a[MD_WIDTH-1], a);
              r_dvsr  <= md_neg_if(b[MD_WIDTH-1], b);
            end
          end
        end
        MULT: begin
          r_cnt <= r_cnt + MD_CNT_W'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_prod[2*MD_WIDTH-1:MD_WIDTH];
            r_lo    <= w_prod[MD_WIDTH-1:0];
          end
        end
        DIV: begin
          r_cnt <= r_cnt + MD_CNT_W'(1);
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_div_hi;
            r_lo    <= w_div_lo;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : directed self-checking bench for mult_div_unit
// Rev 1.0
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  // lat = cycle index (relative to accepting edge N) in which done is seen
  task automatic run_op(input logic m, input logic d, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output logic busy1, output logic dz);
    @(negedge clk);
    start_mult = m; start_div = d; a = va; b = vb;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    lat = 1;
    busy1 = busy;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    dz = div_zero;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", div_zero); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int lat; logic b1, dz;
    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, lat, b1, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL mult_busy got %b exp 1", b1); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_m3x5_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_m3x5_lo got %h exp fffffff1", lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", done); end
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, b1, dz);
    checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi got %h exp 40000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo got %h exp 0", lo); end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'd12345, 32'hFFFF_FD5A, lat, b1, dz);
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFF80_490A) begin errors++; $display("FAIL mult_neg_lo got %h exp ff80490a", lo); end
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, b1, dz);
    checks++; if (hi !== 32'h3FFF_FFFF) begin errors++; $display("FAIL mult_max_hi got %h exp 3fffffff", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL mult_max_lo got %h exp 00000001", lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic b1, dz;
    @(negedge clk);
    start_mult = 1'b1; a = 32'd123; b = 32'd456;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h exp 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    run_op(1'b1, 1'b0, 32'd7, 32'd6, lat, b1, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL midrst_7x6_lo got %h exp 2a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrst_7x6_hi got %h exp 0", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int lat; logic b1, dz;
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, b1, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL div_busy got %b exp 1", b1); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7d2_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7d2_hi got %h exp ffffffff", hi); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b1, dz);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", hi); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'd100, 32'd7, lat, b1, dz);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_100d7_lo got %h exp e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_100d7_hi got %h exp 2", hi); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, b1, dz);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7dm2_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_7dm2_hi got %h exp 1", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration;
    int lat; logic b1, dz; int extra_done;
    run_op(1'b1, 1'b1, 32'd6, 32'd3, lat, b1, dz);
    checks++; if (lo !== 32'd18) begin errors++; $display("FAIL arb_both_lo got %h exp 12", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL arb_both_hi got %h exp 0", hi); end
    @(posedge clk); #1;
    @(negedge clk);
    start_mult = 1'b1; a = 32'd5; b = 32'd4;
    @(posedge clk); #1;
    start_mult = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start_div = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start_div = 1'b0; lat++;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 33) begin errors++; $display("FAIL arb_busy_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'd20) begin errors++; $display("FAIL arb_busy_lo got %h exp 14", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL arb_busy_hi got %h exp 0", hi); end
    extra_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) extra_done++; end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL arb_no_queue got %0d exp 0", extra_done); end
  endtask

  task automatic test_back_to_back;
    int lat; logic b1, dz;
    run_op(1'b1, 1'b0, 32'd2, 32'd3, lat, b1, dz);
    @(negedge clk);
    start_mult = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start_mult = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore_busy got %b exp 0", busy); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo got %h exp 6", lo); end
    run_op(1'b1, 1'b0, 32'd11, 32'hFFFF_FFFE, lat, b1, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFEA) begin errors++; $display("FAIL b2b_lo got %h exp ffffffea", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi got %h exp ffffffff", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat; logic b1, dz;
    run_op(1'b0, 1'b1, 32'd9, 32'd0, lat, b1, dz);
`ifdef MULT_DIV_ZERO_EXC_EN
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL dz_busy got %b exp 0", b1); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", dz); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_hold_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEA) begin errors++; $display("FAIL dz_hold_lo got %h exp ffffffea", lo); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse got %b exp 0", div_zero); end
`else
    checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d exp 33", lat); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_flag got %b exp 0", dz); end
    checks++; if (hi !== 32'd9) begin errors++; $display("FAIL dz_hi got %h exp 9", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h exp ffffffff", lo); end
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0, lat, b1, dz);
    checks++; if (hi !== 32'hFFFF_FFF7) begin errors++; $display("FAIL dz_neg_hi got %h exp fffffff7", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_neg_lo got %h exp ffffffff", lo); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_reset_mid();
    test_div();
    test_arbitration();
    test_back_to_back();
    test_div_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
